// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - JK flip-flop excitation driver with target-bit FIFO and readback check
`timescale 1ns/1ps
module jk_excite_driver #(
    parameter int DEPTH       = 4,
    parameter int ERRW        = 8,
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tgt_valid,
    input  logic            tgt_bit,
    output logic            tgt_ready,
    input  logic            init_req,
    input  logic            q_fb,
    output logic            j,
    output logic            k,
    output logic            ff_rst,
    output logic            busy,
    output logic            err,
    output logic [ERRW-1:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, INIT1, INIT2, DRIVE, APPLY, CHECK} state_t;

    state_t          state_q;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            exp_q, j_q, k_q, ff_rst_q, err_q;
    logic [ERRW-1:0] err_count_q;
    logic            empty, full, push, pop, head, next_j, next_k;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = tgt_valid && !full;
    assign pop   = (state_q == DRIVE);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = tgt_bit;
        end
    end

    always_comb begin
        if (TOGGLE_PREF) begin
            next_j = q_fb ^ head;
            next_k = q_fb ^ head;
        end else begin
            next_j = !q_fb && head;
            next_k = q_fb && !head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= 1'b0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            ff_rst_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q  <= INIT1;
                        ff_rst_q <= 1'b1;
                    end else if (!empty) begin
                        state_q <= DRIVE;
                    end
                end
                INIT1: state_q <= INIT2;
                INIT2: begin
                    state_q  <= CHECK;
                    ff_rst_q <= 1'b0;
                    exp_q    <= 1'b0;
                end
                DRIVE: begin
                    exp_q   <= head;
                    j_q     <= next_j;
                    k_q     <= next_k;
                    state_q <= APPLY;
                end
                APPLY: begin
                    j_q     <= 1'b0;
                    k_q     <= 1'b0;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (q_fb != exp_q) begin
                        err_q <= 1'b1;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + ERRW'(1);
                        end
                    end
                    state_q <= empty ? IDLE : DRIVE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tgt_ready = !full;
    assign busy      = (state_q != IDLE) || !empty;
    assign j         = j_q;
    assign k         = k_q;
    assign ff_rst    = ff_rst_q;
    assign err       = err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - self-checking bench for jk_excite_driver (set/reset and toggle variants)
`timescale 1ns/1ps
module tb_jk_excite_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tgt_valid = 1'b0, tgt_bit = 1'b0, init_req = 1'b0;
    logic tgt_ready0, j0, k0, ff_rst0, busy0, err0;
    logic tgt_ready1, j1, k1, ff_rst1, busy1, err1;
    logic [7:0] err_count0, err_count1;
    logic ffq0 = 1'b1, ffq1 = 1'b1, force0 = 1'b0;
    logic q_fb0, q_fb1;

    assign q_fb0 = force0 ? 1'b0 : ffq0;
    assign q_fb1 = ffq1;

    always #5 clk = ~clk;

    jk_excite_driver #(.DEPTH(4), .ERRW(8), .TOGGLE_PREF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready0),
        .init_req(init_req), .q_fb(q_fb0), .j(j0), .k(k0), .ff_rst(ff_rst0), .busy(busy0),
        .err(err0), .err_count(err_count0));

    jk_excite_driver #(.DEPTH(4), .ERRW(8), .TOGGLE_PREF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready1),
        .init_req(init_req), .q_fb(q_fb1), .j(j1), .k(k1), .ff_rst(ff_rst1), .busy(busy1),
        .err(err1), .err_count(err_count1));

    // External JK flip-flops with synchronous reset input
    always @(posedge clk) begin
        if (ff_rst0) ffq0 <= 1'b0;
        else case ({j0, k0})
            2'b10: ffq0 <= 1'b1;
            2'b01: ffq0 <= 1'b0;
            2'b11: ffq0 <= ~ffq0;
            default: ;
        endcase
        if (ff_rst1) ffq1 <= 1'b0;
        else case ({j1, k1})
            2'b10: ffq1 <= 1'b1;
            2'b01: ffq1 <= 1'b0;
            2'b11: ffq1 <= ~ffq1;
            default: ;
        endcase
    end

    int   n_chk = 0, n_pass = 0;
    int   err_pulses0 = 0, err_pulses1 = 0;
    logic err_prev0 = 1'b0, err_double0 = 1'b0, both0 = 1'b0, mon_en = 1'b0;
    logic lq0 = 1'b1, lq1 = 1'b1;
    logic       qchg0[$], qchg1[$];
    logic [1:0] jklog0[$], jklog1[$];

    always @(negedge clk) begin
        if (err0 === 1'b1) begin
            err_pulses0++;
            if (err_prev0) err_double0 = 1'b1;
        end
        if (err1 === 1'b1) err_pulses1++;
        err_prev0 = (err0 === 1'b1);
        if (j0 === 1'b1 && k0 === 1'b1) both0 = 1'b1;
        if (mon_en) begin
            if (q_fb0 != lq0) qchg0.push_back(q_fb0);
            if (q_fb1 != lq1) qchg1.push_back(q_fb1);
            if (j0 || k0) jklog0.push_back({j0, k0});
            if (j1 || k1) jklog1.push_back({j1, k1});
        end
        lq0 = q_fb0;
        lq1 = q_fb1;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    typedef struct packed {
        logic       b;
        logic [1:0] jk0;
        logic [1:0] jk1;
        logic       q;
    } vec_t;

    vec_t       vt[4];
    logic [4:0] b36 = 5'b01101;
    logic [3:0] b38 = 4'b0101;
    int         accept_cyc[5];
    int         idx, base0, base1, ffcnt, n_acc, vi;
    logic       acc, cur0, cur1, ok;
    logic       acc_q[$], eq0[$], eq1[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 2'b10, 2'b11, 1'b1};
        vt[1] = '{1'b1, 2'b00, 2'b00, 1'b1};
        vt[2] = '{1'b0, 2'b01, 2'b11, 1'b0};
        vt[3] = '{1'b0, 2'b00, 2'b00, 1'b0};

        // Reset values, asynchronous (before any clock edge)
        #2 rst = 1'b1;
        #2;
        check("rst_j", int'(j0), 0);
        check("rst_k", int'(k0), 0);
        check("rst_ff_rst", int'(ff_rst0), 0);
        check("rst_err", int'(err0), 0);
        check("rst_err_count", int'(err_count0), 0);
        check("rst_tgt_ready", int'(tgt_ready0), 1);
        check("rst_busy", int'(busy0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Flip-flop init sequence, flops start at Q=1
        base0 = err_pulses0;
        init_req = 1'b1;
        ffcnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            init_req = 1'b0;
            if (ff_rst0) ffcnt++;
            if (c == 1) check("init_jk_zero", int'({j0, k0}), 0);
            if (c <= 2) check("init_ff_rst_high", int'(ff_rst0), 1);
            if (c == 3) begin
                check("init_q0", int'(q_fb0), 0);
                check("init_q1", int'(q_fb1), 0);
            end
            if (c == 4) begin
                check("init_err", int'(err0), 0);
                check("init_busy_low", int'(busy0), 0);
            end
        end
        check("init_ff_rst_cycles", ffcnt, 2);
        @(negedge clk);
        check("init_err_pulses", err_pulses0 - base0, 0);
        check("init_err_count", int'(err_count0), 0);

        // Table-driven: push 1,1,0,0 from Q=0; DRIVE at cycle 2, APPLY at 3+3i, Q valid at 4+3i
        for (int cyc = 0; cyc <= 14; cyc++) begin
            if (cyc < 4) begin
                tgt_valid = 1'b1;
                tgt_bit = vt[cyc].b;
            end else begin
                tgt_valid = 1'b0;
            end
            if (cyc == 1) check("tbl_not_same_cycle", int'({j0, k0}), 0);
            if (cyc == 2) check("tbl_busy_drive", int'(busy0), 1);
            if (cyc >= 3 && (cyc - 3) % 3 == 0) begin
                vi = (cyc - 3) / 3;
                check($sformatf("tbl_jk0_%0d", vi), int'({j0, k0}), int'(vt[vi].jk0));
                check($sformatf("tbl_jk1_%0d", vi), int'({j1, k1}), int'(vt[vi].jk1));
            end
            if (cyc >= 4 && (cyc - 4) % 3 == 0) begin
                vi = (cyc - 4) / 3;
                check($sformatf("tbl_q0_%0d", vi), int'(q_fb0), int'(vt[vi].q));
                check($sformatf("tbl_q1_%0d", vi), int'(q_fb1), int'(vt[vi].q));
            end
            if (cyc == 13) check("tbl_busy_last_check", int'(busy0), 1);
            if (cyc == 14) check("tbl_busy_fall", int'(busy0), 0);
            @(negedge clk);
        end
        check("tbl_err_count0", int'(err_count0), 0);
        check("tbl_err_count1", int'(err_count1), 0);

        // Five back-to-back pushes while the FSM is stalled in INIT
        init_req = 1'b1;
        tgt_valid = 1'b1;
        idx = 0;
        tgt_bit = b36[0];
        for (int cyc = 1; cyc <= 19; cyc++) begin
            acc = tgt_valid && tgt_ready0;
            @(negedge clk);
            init_req = 1'b0;
            if (acc) begin
                accept_cyc[idx] = cyc;
                idx++;
            end
            if (idx < 5) tgt_bit = b36[idx];
            else tgt_valid = 1'b0;
            if (cyc == 4) check("fifo_full_ready_low", int'(tgt_ready0), 0);
            if (cyc >= 6 && (cyc - 6) % 3 == 0 && (cyc - 6) / 3 < 5) begin
                vi = (cyc - 6) / 3;
                check($sformatf("fifo_order_q_%0d", vi), int'(q_fb0), int'(b36[vi]));
            end
            if (cyc == 19) check("fifo_busy_fall", int'(busy0), 0);
        end
        check("fifo_accepted", idx, 5);
        check("fifo_fifth_accept_cycle", accept_cyc[4], 6);

        // Readback forced low while pushing 300 ones: err every CHECK, counter saturates
        base0 = err_pulses0;
        base1 = err_pulses1;
        force0 = 1'b1;
        tgt_valid = 1'b1;
        tgt_bit = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 3000 && n_acc < 300; c++) begin
            if (tgt_ready0) n_acc++;
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        for (int c = 0; c < 100 && busy0; c++) @(negedge clk);
        check("sat_drain", int'(busy0), 0);
        @(negedge clk);
        @(negedge clk);
        check("sat_pushed", n_acc, 300);
        check("sat_err_pulses", err_pulses0 - base0, 300);
        check("sat_err_single_cycle", int'(err_double0), 0);
        check("sat_err_count0", int'(err_count0), 255);
        check("sat_err_count1", int'(err_count1), 0);
        check("sat_err_pulses1", err_pulses1 - base1, 0);
        force0 = 1'b0;

        // Reset pulsed during APPLY with three bits queued
        init_req = 1'b1;
        tgt_valid = 1'b1;
        idx = 0;
        tgt_bit = b38[0];
        for (int cyc = 1; cyc <= 5; cyc++) begin
            acc = tgt_valid && tgt_ready0;
            @(negedge clk);
            init_req = 1'b0;
            if (acc) idx++;
            if (idx < 4) tgt_bit = b38[idx];
            else tgt_valid = 1'b0;
        end
        check("rstmid_apply_jk", int'({j0, k0}), 2);
        check("rstmid_pushed", idx, 4);
        base0 = err_pulses0;
        #2 rst = 1'b1;
        #1;
        check("rstmid_j", int'(j0), 0);
        check("rstmid_k", int'(k0), 0);
        check("rstmid_ff_rst", int'(ff_rst0), 0);
        check("rstmid_err_count", int'(err_count0), 0);
        check("rstmid_ready", int'(tgt_ready0), 1);
        check("rstmid_busy", int'(busy0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_busy_after", int'(busy0), 0);
        check("rstmid_q_kept", int'(q_fb0), 0);
        check("rstmid_no_err", err_pulses0 - base0, 0);
        tgt_valid = 1'b1;
        tgt_bit = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_post_jk", int'({j0, k0}), 2);
        @(negedge clk);
        check("rstmid_post_q0", int'(q_fb0), 1);
        check("rstmid_post_q1", int'(q_fb1), 1);
        for (int c = 0; c < 100 && busy0; c++) @(negedge clk);
        @(negedge clk);

        // Randomized stream against a Q-trajectory model
        cur0 = q_fb0;
        cur1 = q_fb1;
        mon_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_bit = 1'($urandom_range(0, 1));
            if (tgt_valid && tgt_ready0) acc_q.push_back(tgt_bit);
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        for (int c = 0; c < 300 && busy0; c++) @(negedge clk);
        check("rand_drain", int'(busy0), 0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        foreach (acc_q[i]) begin
            if (acc_q[i] != cur0) begin
                eq0.push_back(acc_q[i]);
                cur0 = acc_q[i];
            end
            if (acc_q[i] != cur1) begin
                eq1.push_back(acc_q[i]);
                cur1 = acc_q[i];
            end
        end
        check("rand_q0_changes", qchg0.size(), eq0.size());
        check("rand_q1_changes", qchg1.size(), eq1.size());
        check("rand_jk0_count", jklog0.size(), eq0.size());
        check("rand_jk1_count", jklog1.size(), eq1.size());
        ok = 1'b1;
        foreach (eq0[i]) begin
            if (i < qchg0.size() && qchg0[i] != eq0[i]) ok = 1'b0;
            if (i < jklog0.size() && jklog0[i] != (eq0[i] ? 2'b10 : 2'b01)) ok = 1'b0;
        end
        check("rand_seq0", int'(ok), 1);
        ok = 1'b1;
        foreach (eq1[i]) begin
            if (i < qchg1.size() && qchg1[i] != eq1[i]) ok = 1'b0;
            if (i < jklog1.size() && jklog1[i] != 2'b11) ok = 1'b0;
        end
        check("rand_seq1", int'(ok), 1);
        if (acc_q.size() > 0) check("rand_final_q0", int'(q_fb0), int'(acc_q[acc_q.size() - 1]));
        check("rand_err_count0", int'(err_count0), 0);
        check("rand_err_count1", int'(err_count1), 0);
        check("never_j_and_k", int'(both0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter DEPTH, default 4, target-bit FIFO depth (power of 2, >=2).
REQ-002 Parameter ERRW, default 8, error-counter width.
REQ-003 Parameter TOGGLE_PREF, default 0; 1 = drive transitions with J=K=1 (toggle) instead of set/reset.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tgt_valid  input  1  target bit offered.
REQ-007 tgt_bit  input  1  desired next Q of the driven JK flip-flop.
REQ-008 tgt_ready  output  1  FIFO not full; transfer when tgt_valid&&tgt_ready at posedge.
REQ-009 init_req  input  1  request external flip-flop reset; sampled only in IDLE.
REQ-010 q_fb  input  1  Q of the driven JK flip-flop.
REQ-011 j  output  1  J drive, registered.
REQ-012 k  output  1  K drive, registered.
REQ-013 ff_rst  output  1  reset drive to the external flip-flop, registered.
REQ-014 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-015 err  output  1  one-cycle pulse on any check mismatch.
REQ-016 err_count  output  ERRW  saturating mismatch count.

Function
REQ-017 FSM states: IDLE, INIT1, INIT2, DRIVE, APPLY, CHECK.
REQ-018 IDLE: init_req=1 -> INIT1 (priority over FIFO); else FIFO non-empty -> DRIVE; else stay.
REQ-019 INIT1/INIT2: ff_rst=1 for exactly these two cycles, j=k=0; INIT2 -> CHECK with expected value 0.
REQ-020 DRIVE: pop FIFO head into exp register; register j,k from (q_fb, exp); -> APPLY.
REQ-021 Excitation, TOGGLE_PREF=0: 0->0 J0K0; 0->1 J1K0; 1->0 J0K1; 1->1 J0K0.
REQ-022 Excitation, TOGGLE_PREF=1: transitions (0->1, 1->0) J1K1; holds J0K0.
REQ-023 APPLY: j,k held one full cycle so the flip-flop captures them at APPLY's closing edge; j,k return to 0 at that edge; -> CHECK.
REQ-024 CHECK: at closing edge compare q_fb with exp; mismatch -> err=1 next cycle, err_count+1 saturating at all-ones; -> DRIVE if FIFO non-empty, else IDLE.
REQ-025 Per-bit latency: 3 cycles (DRIVE, APPLY, CHECK) back-to-back; an idle FIFO adds one IDLE cycle.
REQ-026 FIFO: circular, wrap-around pointers with one extra bit; full when pointers differ only in MSB; tgt_ready = !full.
REQ-027 Simultaneous push and pop in DRIVE on a full FIFO: only the pop counts that cycle (tgt_ready low); push accepted next cycle.
REQ-028 Push when empty and in IDLE: bit enters DRIVE on the following cycle, never the same cycle.
REQ-029 init_req outside IDLE is ignored, not latched.
REQ-030 j and k are never both 1 when TOGGLE_PREF=0.

Reset
REQ-031 rst asserted: state=IDLE, FIFO emptied, j=k=0, ff_rst=0, err=0, err_count=0, tgt_ready=1, busy=0 immediately, independent of clk.
REQ-032 rst mid-operation discards in-flight and queued bits, with no err pulse; first post-reset edge behaves as IDLE.

Verification
REQ-033 init_req=1 in IDLE with flip-flop attached -> ff_rst high 2 cycles, q_fb=0, err never pulses, err_count=0.
REQ-034 From Q=0, push 1,1,0,0 -> j/k in APPLY = 10,00,01,00; Q follows 1,1,0,0; err_count=0; busy falls 12 cycles after first DRIVE.
REQ-035 TOGGLE_PREF=1, push 1,0 from Q=0 -> j=k=1 in both APPLY cycles; Q=1 then 0; no errors.
REQ-036 Push 5 bits back-to-back with DEPTH=4 while stalled in INIT -> tgt_ready low after 4th accept; 5th accepted after first pop; all 5 driven in order.
REQ-037 q_fb forced to 0 while pushing 1 x 300 -> err pulses on each CHECK; err_count saturates at 255.
REQ-038 rst pulsed during APPLY with 3 bits queued -> outputs zero asynchronously; busy=0; no err; subsequent push drives correctly.
